// File: rtl/rc4_pkg.sv
// ============================================================================
//  Module      : rc4_pkg
//  Description : Shared definitions for the RC4 PRGA decryptor: S-array
//                size and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rc4_pkg;

    // Number of entries in the RC4 permutation array.
    localparam int S_SIZE = 256;

    // Controller states. One byte of keystream costs one pass RD_I..WR_PT.
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_I   = 4'd1,
        ST_WAIT_I = 4'd2,
        ST_RD_J   = 4'd3,
        ST_WAIT_J = 4'd4,
        ST_WR_I   = 4'd5,
        ST_WR_J   = 4'd6,
        ST_RD_F   = 4'd7,
        ST_WAIT_F = 4'd8,
        ST_WR_PT  = 4'd9,
        ST_DONE   = 4'd10
    } prga_state_e;

endpackage

`default_nettype wire

// File: rtl/prga_decrypt_datapath.sv
// ============================================================================
//  Module      : prga_datapath
//  Description : RC4 PRGA datapath. Holds i, j, k, S[i], S[j], keystream
//                byte f and ciphertext byte ct, and decodes the controller
//                state into S-RAM and plaintext-RAM address/data/enables.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                state           - current controller state
//                clear           - start of run: zero i, j, k
//                s_rdata/ct_rdata- RAM/ROM read data (1-cycle latency)
//                s_*/ct_*/pt_*   - memory interface outputs
//                more_bytes      - k+1 < MSG_LEN (evaluated in WR_PT)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prga_datapath
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int AW      = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  prga_state_e   state,
    input  logic          clear,
    input  logic [7:0]    s_rdata,
    input  logic [7:0]    ct_rdata,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_wren,
    output logic [AW-1:0] ct_addr,
    output logic [AW-1:0] pt_addr,
    output logic [7:0]    pt_wdata,
    output logic          pt_wren,
    output logic          more_bytes
);

    localparam int C_IDX_W = $clog2(S_SIZE);
    // k carries one spare bit so k == MSG_LEN is representable without wrap.
    localparam int C_KW = AW + 1;
    localparam logic [C_KW-1:0] C_MSG_LEN = C_KW'(MSG_LEN);

    logic [C_IDX_W-1:0] i_q,  i_d;
    logic [C_IDX_W-1:0] j_q,  j_d;
    logic [C_KW-1:0]    k_q,  k_d;
    logic [7:0]         si_q, si_d;
    logic [7:0]         sj_q, sj_d;
    logic [7:0]         f_q,  f_d;
    logic [7:0]         ct_q, ct_d;

    logic               w_s_wr;
    logic               w_pt_wr;
    logic [C_KW-1:0]    w_k_inc;

    assign w_k_inc    = k_q + C_KW'(1);
    assign more_bytes = (w_k_inc < C_MSG_LEN);

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        f_d     = f_q;
        ct_d    = ct_q;
        s_addr  = 8'd0;
        s_wdata = 8'd0;
        w_s_wr  = 1'b0;
        w_pt_wr = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (clear) begin
                    i_d = '0;
                    j_d = '0;
                    k_d = '0;
                end
            end
            ST_RD_I: begin
                s_addr = i_q + 8'd1;
                i_d    = i_q + 8'd1;
            end
            ST_WAIT_I: begin
                si_d = s_rdata;
                j_d  = j_q + s_rdata;
            end
            ST_RD_J: begin
                s_addr = j_q;
            end
            ST_WAIT_J: begin
                sj_d = s_rdata;
            end
            // When i == j both writes hit one address; the second rewrites
            // the original value, so S[i] is left unchanged.
            ST_WR_I: begin
                s_addr  = i_q;
                s_wdata = sj_q;
                w_s_wr  = 1'b1;
            end
            ST_WR_J: begin
                s_addr  = j_q;
                s_wdata = si_q;
                w_s_wr  = 1'b1;
            end
            ST_RD_F: begin
                s_addr = si_q + sj_q;
            end
            ST_WAIT_F: begin
                f_d  = s_rdata;
                ct_d = ct_rdata;
            end
            ST_WR_PT: begin
                w_pt_wr = 1'b1;
                k_d     = w_k_inc;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst so a reset cycle can never commit a write.
    assign s_wren   = w_s_wr  & ~rst;
    assign pt_wren  = w_pt_wr & ~rst;
    assign pt_wdata = f_q ^ ct_q;
    assign ct_addr  = k_q[AW-1:0];
    assign pt_addr  = k_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            si_q <= '0;
            sj_q <= '0;
            f_q  <= '0;
            ct_q <= '0;
        end else begin
            i_q  <= i_d;
            j_q  <= j_d;
            k_q  <= k_d;
            si_q <= si_d;
            sj_q <= sj_d;
            f_q  <= f_d;
            ct_q <= ct_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prga_decrypt.sv
// ============================================================================
//  Module      : prga_decrypt
//  Description : RC4 PRGA decryptor. Walks an already key-scheduled S-array
//                in external RAM, XORs the keystream with MSG_LEN ciphertext
//                bytes and writes the plaintext. 9 cycles per byte.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                start / done       - run request / run complete (level)
//                s_addr, s_wdata, s_wren, s_rdata - S-array RAM
//                ct_addr, ct_rdata  - ciphertext ROM
//                pt_addr, pt_wdata, pt_wren        - plaintext RAM
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prga_decrypt
    import rc4_pkg::*;
#(
    parameter  int MSG_LEN = 32,
    localparam int AW      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_wdata,
    output logic          s_wren,
    input  logic [7:0]    s_rdata,
    output logic [AW-1:0] ct_addr,
    input  logic [7:0]    ct_rdata,
    output logic [AW-1:0] pt_addr,
    output logic [7:0]    pt_wdata,
    output logic          pt_wren
);

    prga_state_e state_q, state_d;
    logic        w_clear;
    logic        w_more_bytes;

    // start is only looked at in IDLE and DONE; every other state simply
    // advances along the fixed 9-state byte sequence.
    always_comb begin
        state_d = state_q;
        w_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RD_I;
                    w_clear = 1'b1;
                end
            end
            ST_RD_I:   state_d = ST_WAIT_I;
            ST_WAIT_I: state_d = ST_RD_J;
            ST_RD_J:   state_d = ST_WAIT_J;
            ST_WAIT_J: state_d = ST_WR_I;
            ST_WR_I:   state_d = ST_WR_J;
            ST_WR_J:   state_d = ST_RD_F;
            ST_RD_F:   state_d = ST_WAIT_F;
            ST_WAIT_F: state_d = ST_WR_PT;
            ST_WR_PT:  state_d = w_more_bytes ? ST_RD_I : ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign done = (state_q == ST_DONE);

    prga_datapath #(
        .MSG_LEN (MSG_LEN),
        .AW      (AW)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .state      (state_q),
        .clear      (w_clear),
        .s_rdata    (s_rdata),
        .ct_rdata   (ct_rdata),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wren     (s_wren),
        .ct_addr    (ct_addr),
        .pt_addr    (pt_addr),
        .pt_wdata   (pt_wdata),
        .pt_wren    (pt_wren),
        .more_bytes (w_more_bytes)
    );

endmodule

`default_nettype wire

// File: tb/tb_prga_decrypt.sv
// ============================================================================
//  Module      : tb_prga_decrypt
//  Description : Scoreboard bench for prga_decrypt (MSG_LEN = 32) with
//                behavioural RC4 reference model and RAM/ROM models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prga_decrypt;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       done;
    logic [7:0] s_addr, s_wdata, s_rdata;
    logic       s_wren;
    logic [4:0] ct_addr, pt_addr;
    logic [7:0] ct_rdata, pt_wdata;
    logic       pt_wren;

    logic [7:0] smem   [256];
    logic [7:0] s_init [256];
    logic [7:0] ctmem  [N];
    logic [7:0] ptmem  [N];
    logic       s_load;

    int         mdl_s [256];
    logic [15:0] exp_q [$];

    int total = 0;
    int bad   = 0;
    int n_swr = 0;
    int n_pwr = 0;

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .done     (done),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wren   (s_wren),
        .s_rdata  (s_rdata),
        .ct_addr  (ct_addr),
        .ct_rdata (ct_rdata),
        .pt_addr  (pt_addr),
        .pt_wdata (pt_wdata),
        .pt_wren  (pt_wren)
    );

    // Memory models: synchronous reads, one-cycle latency.
    always @(posedge clk) begin
        s_rdata  <= smem[s_addr];
        ct_rdata <= ctmem[ct_addr];
        if (s_load) begin
            for (int x = 0; x < 256; x++) smem[x] <= s_init[x];
        end else if (s_wren) begin
            smem[s_addr] <= s_wdata;
        end
        if (pt_wren) ptmem[pt_addr] <= pt_wdata;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Monitor: every plaintext write is matched against the scoreboard.
    always @(negedge clk) begin
        if (s_wren) n_swr++;
        if (pt_wren) begin
            n_pwr++;
            if (exp_q.size() == 0) begin
                fail_now("unexpected_pt_write");
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("pt_addr", int'(pt_addr), int'(e[15:8]));
                chk("pt_data", int'(pt_wdata), int'(e[7:0]));
            end
        end
    end

    // Reference RC4 PRGA over mdl_s: runs nbytes rounds, pushes the
    // expected plaintext of the first npush bytes.
    task automatic model_run(input int nbytes, input int npush);
        int i = 0, j = 0, t, f;
        logic [15:0] e;
        for (int k = 0; k < nbytes; k++) begin
            i = (i + 1) % 256;
            j = (j + mdl_s[i]) % 256;
            t = mdl_s[i]; mdl_s[i] = mdl_s[j]; mdl_s[j] = t;
            f = mdl_s[(mdl_s[i] + mdl_s[j]) % 256];
            if (k < npush) begin
                e[15:8] = 8'(k);
                e[7:0]  = 8'(f) ^ ctmem[k];
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic model_ksa(input int k0, input int k1, input int k2);
        int key [3];
        int j = 0, t;
        key[0] = k0; key[1] = k1; key[2] = k2;
        for (int x = 0; x < 256; x++) mdl_s[x] = x;
        for (int x = 0; x < 256; x++) begin
            j = (j + mdl_s[x] + key[x % 3]) % 256;
            t = mdl_s[x]; mdl_s[x] = mdl_s[j]; mdl_s[j] = t;
        end
    endtask

    task automatic model_shuffle();
        int r, t;
        for (int x = 0; x < 256; x++) mdl_s[x] = x;
        for (int x = 255; x > 0; x--) begin
            r = int'($urandom_range(x, 0));
            t = mdl_s[x]; mdl_s[x] = mdl_s[r]; mdl_s[r] = t;
        end
    endtask

    task automatic load_s();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(mdl_s[x]);
        s_load = 1'b1;
        @(posedge clk);
        #1 s_load = 1'b0;
    endtask

    task automatic chk_s(input string name);
        int mm = 0;
        for (int x = 0; x < 256; x++) if (smem[x] != 8'(mdl_s[x])) mm++;
        chk(name, mm, 0);
    endtask

    // Issues start and waits for done. lat counts clock edges from the
    // edge that samples start up to the edge after which done is seen.
    task automatic do_run(input bit hold, output int lat);
        lat   = 0;
        start = 1'b1;
        while (1) begin
            @(posedge clk);
            lat++;
            #1;
            if (!hold) start = 1'b0;
            @(negedge clk);
            if (done) break;
            if (lat > 2000) begin
                fail_now("run_timeout");
                break;
            end
        end
    endtask

    task automatic std_run(input string name);
        int lat, swr0, pwr0;
        swr0 = n_swr;
        pwr0 = n_pwr;
        model_run(N, N);
        do_run(1'b0, lat);
        chk({name, "_latency"}, lat, 9 * N + 1);
        chk({name, "_s_wren_cnt"}, n_swr - swr0, 2 * N);
        chk({name, "_pt_wren_cnt"}, n_pwr - pwr0, N);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        @(posedge clk);
        #1 chk_s({name, "_s_final"});
    endtask

    initial begin
        int lat, swr0, pwr0;
        logic [7:0] kat_ct [9];
        logic [7:0] kat_pt [9];
        kat_ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        kat_pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};

        rst    = 1'b1;
        start  = 1'b0;
        s_load = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_done", int'(done), 0);
        chk("rst_s_wren", int'(s_wren), 0);
        chk("rst_pt_wren", int'(pt_wren), 0);
        chk("rst_ct_addr", int'(ct_addr), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Identity S, zero ciphertext: keystream starts 02 05.
        for (int x = 0; x < 256; x++) mdl_s[x] = x;
        for (int k = 0; k < N; k++) ctmem[k] = 8'h00;
        load_s();
        std_run("ident");
        chk("ident_pt0", int'(ptmem[0]), 8'h02);
        chk("ident_pt1", int'(ptmem[1]), 8'h05);

        // Key "Key" test vector, remaining ciphertext random.
        model_ksa(8'h4B, 8'h65, 8'h79);
        for (int k = 0; k < N; k++) ctmem[k] = 8'($urandom);
        for (int k = 0; k < 9; k++) ctmem[k] = kat_ct[k];
        load_s();
        std_run("key");
        for (int k = 0; k < 9; k++) chk("key_plaintext", int'(ptmem[k]), int'(kat_pt[k]));

        // start held high: one run, then a rerun from DONE on permuted S.
        model_shuffle();
        for (int k = 0; k < N; k++) ctmem[k] = 8'($urandom);
        load_s();
        pwr0 = n_pwr;
        model_run(N, N);
        do_run(1'b1, lat);
        chk("hold_latency", lat, 9 * N + 1);
        chk("hold_pt_wren_cnt", n_pwr - pwr0, N);
        model_run(N, N);
        do_run(1'b0, lat);
        chk("rerun_latency", lat, 9 * N + 1);
        chk("rerun_pt_wren_cnt", n_pwr - pwr0, 2 * N);
        @(posedge clk);
        #1 chk_s("rerun_s_final");

        // Random permutations and ciphertexts.
        for (int r = 0; r < 3; r++) begin
            model_shuffle();
            for (int k = 0; k < N; k++) ctmem[k] = 8'($urandom);
            load_s();
            std_run("rand");
        end

        // rst and start together in DONE: reset must win.
        @(negedge clk);
        pwr0  = n_pwr;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start  = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_prio_pt_wren_cnt", n_pwr - pwr0, 0);
        chk("rst_prio_done", int'(done), 0);

        // Reset during WR_PT of byte 5.
        model_shuffle();
        for (int k = 0; k < N; k++) ctmem[k] = 8'($urandom);
        load_s();
        model_run(6, 5);
        swr0 = n_swr;
        pwr0 = n_pwr;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (1) begin
            @(negedge clk);
            if (pt_wren && pt_addr == 5'd4) break;
            lat++;
            if (lat > 200) begin
                fail_now("abort_wait_timeout");
                break;
            end
        end
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("abort_pt_wren_same_cycle", int'(pt_wren), 0);
        @(posedge clk);
        #1;
        chk("abort_done", int'(done), 0);
        chk("abort_s_wren", int'(s_wren), 0);
        chk("abort_pt_wren", int'(pt_wren), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_s_wren_cnt", n_swr - swr0, 12);
        chk("abort_pt_wren_cnt", n_pwr - pwr0, 5);
        chk("abort_queue_left", exp_q.size(), 0);
        chk("abort_idle_done", int'(done), 0);
        chk_s("abort_s_kept");

        // Fresh run from IDLE on the partially permuted S.
        std_run("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 Parameter: MSG_LEN, 32, number of ciphertext bytes processed per run (1..256).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  sampled only in IDLE or DONE; high starts a run.
REQ-005 Port: done  out  1  high while in DONE; low otherwise.
REQ-006 Port: s_addr  out  8  S-array RAM address (shuffled by the preceding key-schedule stage).
REQ-007 Port: s_wdata  out  8  S-array write data.
REQ-008 Port: s_wren  out  1  S-array write enable.
REQ-009 Port: s_rdata  in  8  S-array read data; valid the cycle after s_addr is driven.
REQ-010 Port: ct_addr  out  $clog2(MSG_LEN) (min 1)  ciphertext ROM address, equal to byte index k.
REQ-011 Port: ct_rdata  in  8  ciphertext byte; valid the cycle after ct_addr is driven.
REQ-012 Port: pt_addr  out  $clog2(MSG_LEN) (min 1)  plaintext RAM address, equal to k.
REQ-013 Port: pt_wdata  out  8  plaintext byte.
REQ-014 Port: pt_wren  out  1  plaintext write enable.

Function
REQ-015 The block SHALL implement the RC4 PRGA: for k = 0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; f=S[(S[i]+S[j]) mod 256]; pt[k]=f XOR ct[k].
REQ-016 i, j and the index sum SHALL be 8-bit, wrapping mod 256; k SHALL be one bit wider than needed to hold MSG_LEN-1, so termination is detected without wrap.
REQ-017 FSM states SHALL be IDLE, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, RD_F, WAIT_F, WR_PT, DONE.
REQ-018 IDLE/DONE: start=1 -> i=0, j=0, k=0, go to RD_I; otherwise hold.
REQ-019 RD_I: s_addr=i+1, i<=i+1. WAIT_I: si<=s_rdata, j<=j+s_rdata.
REQ-020 RD_J: s_addr=j. WAIT_J: sj<=s_rdata.
REQ-021 WR_I: s_addr=i, s_wdata=sj, s_wren=1. WR_J: s_addr=j, s_wdata=si, s_wren=1.
REQ-022 RD_F: s_addr=si+sj. WAIT_F: f<=s_rdata, ct<=ct_rdata.
REQ-023 WR_PT: pt_addr=k, pt_wdata=f XOR ct, pt_wren=1, k<=k+1; next RD_I if k+1<MSG_LEN, else DONE.
REQ-024 Each byte SHALL take exactly 9 cycles; run latency from start sample to done high SHALL be 9*MSG_LEN+1 cycles.
REQ-025 When i==j, both swap writes SHALL target the same address, and S[i] SHALL end unchanged.
REQ-026 s_wren and pt_wren SHALL be high only in WR_I/WR_J and WR_PT respectively; each SHALL be a single-cycle pulse per state visit.
REQ-027 start SHALL be ignored in every state except IDLE and DONE.
REQ-028 ct_addr SHALL equal k in every state.

Reset
REQ-029 rst SHALL force IDLE and zero i, j, k, si, sj, f, ct; done=0, s_wren=0 and pt_wren=0 on the following cycle.
REQ-030 rst asserted mid-run SHALL abort with no further S or plaintext writes; the already modified S contents are not restored.
REQ-031 rst SHALL take priority over start in the same cycle.

Structure
REQ-032 Shared package rc4_pkg SHALL hold the FSM state enum and constant S_SIZE=256.
REQ-033 The design SHALL be split into an FSM controller plus one sub-module, prga_datapath, holding i, j, k, si, sj, f, ct and the address/data muxes.

Verification
REQ-034 S identity (S[x]=x), ct all 0x00, MSG_LEN=2 -> pt[0]=0x02, pt[1]=0x05; afterwards S[2]=0x03, S[3]=0x02.
REQ-035 S produced by key schedule with key 0x4B6579 ("Key"), MSG_LEN=9, ct=BB F3 16 E8 D9 40 AF 0A D3 -> pt="Plaintext" (50 6C 61 69 6E 74 65 78 74).
REQ-036 start pulse, MSG_LEN=32 -> done rises exactly 289 cycles later; exactly 64 s_wren pulses and 32 pt_wren pulses.
REQ-037 rst asserted during WR_PT of byte 5 -> no pt_wren that cycle onward, state IDLE, done=0.
REQ-038 start held high throughout a run -> one run only until DONE; a second start in DONE reruns with i=j=0 on the already-permuted S.
